// File: rtl/game_sequencer.sv
// game_sequencer: pinball game-flow controller.
// Frame-paced phases, ball count, tilt window and gated scoring.
module game_sequencer #(
  parameter int BALLS_PER_GAME = 3,
  parameter int TILT_LIMIT     = 3,
  parameter int TILT_WINDOW    = 120,
  parameter int DRAIN_FRAMES   = 90,
  parameter int OVER_FRAMES    = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       launch_btn,
  input  logic       shake_btn,
  input  logic       ball_lost,
  input  logic       score_in,
  output logic [2:0] state,
  output logic       ball_enable,
  output logic       flipper_enable,
  output logic       launch,
  output logic       score_clear,
  output logic       score_out,
  output logic [2:0] balls_left,
  output logic       tilt,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    TILT  = 3'd3,
    DRAIN = 3'd4,
    OVER  = 3'd5
  } st_t;

  localparam logic [2:0] BALLS  = 3'(BALLS_PER_GAME);
  localparam logic [2:0] T_LIM  = 3'(TILT_LIMIT);
  localparam logic [7:0] T_WIN  = 8'(TILT_WINDOW);
  localparam logic [7:0] D_FRM  = 8'(DRAIN_FRAMES);
  localparam logic [7:0] O_FRM  = 8'(OVER_FRAMES);

  st_t        st;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] smp;
  logic [2:0] press;
  logic       start_p;
  logic       launch_p;
  logic       shake_p;
  logic [2:0] tcnt;
  logic [7:0] win;
  logic [7:0] fcnt;
  logic       win_exp;
  logic [2:0] tbase;
  logic [2:0] tnext;
  logic       tilt_hit;
  logic       f_exp;
  logic [2:0] balls_dec;

  // bit 0 start, bit 1 launch, bit 2 shake
  assign press    = {3{frame_tick}} & sync2 & ~smp;
  assign start_p  = press[0];
  assign launch_p = press[1];
  assign shake_p  = press[2];

  // a press landing on the expiring tick starts a fresh window
  assign win_exp  = frame_tick && (win == 8'd1);
  assign tbase    = win_exp ? 3'd0 : tcnt;
  assign tnext    = (tbase == 3'd7) ? 3'd7 : tbase + 3'd1;
  assign tilt_hit = shake_p && (tnext >= T_LIM);

  assign f_exp     = frame_tick && (fcnt <= 8'd1);
  assign balls_dec = (balls_left == 3'd0) ? 3'd0
                                          : balls_left - 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      sync1       <= '0;
      sync2       <= '0;
      smp         <= '0;
      tcnt        <= '0;
      win         <= '0;
      fcnt        <= '0;
      balls_left  <= '0;
      launch      <= 1'b0;
      score_clear <= 1'b0;
      score_out   <= 1'b0;
    end else begin
      sync1 <= {shake_btn, launch_btn, start_btn};
      sync2 <= sync1;
      if (frame_tick) smp <= sync2;
      launch      <= 1'b0;
      score_clear <= 1'b0;
      score_out   <= score_in && (st == PLAY);
      unique case (st)
        IDLE: begin
          if (start_p) begin
            score_clear <= 1'b1;
            balls_left  <= BALLS;
            st          <= SERVE;
          end
        end
        SERVE: begin
          if (launch_p) begin
            launch <= 1'b1;
            tcnt   <= '0;
            win    <= '0;
            st     <= PLAY;
          end
        end
        PLAY: begin
          if (shake_p) begin
            tcnt <= tnext;
            if (tbase == 3'd0) win <= T_WIN;
            else if (win != 8'd0) win <= win - 8'd1;
          end else if (frame_tick && win != 8'd0) begin
            win <= win - 8'd1;
            if (win_exp) tcnt <= '0;
          end
          if (ball_lost) begin
            balls_left <= balls_dec;
            fcnt       <= D_FRM;
            st         <= DRAIN;
          end else if (tilt_hit) begin
            st <= TILT;
          end
        end
        TILT: begin
          if (ball_lost) begin
            balls_left <= balls_dec;
            fcnt       <= D_FRM;
            st         <= DRAIN;
          end
        end
        DRAIN: begin
          if (f_exp) begin
            if (balls_left == 3'd0) begin
              fcnt <= O_FRM;
              st   <= OVER;
            end else begin
              fcnt <= '0;
              st   <= SERVE;
            end
          end else if (frame_tick) begin
            fcnt <= fcnt - 8'd1;
          end
        end
        OVER: begin
          if (start_p) begin
            score_clear <= 1'b1;
            balls_left  <= BALLS;
            fcnt        <= '0;
            st          <= SERVE;
          end else if (f_exp) begin
            fcnt <= '0;
            st   <= IDLE;
          end else if (frame_tick) begin
            fcnt <= fcnt - 8'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state = st;

  always_comb begin
    ball_enable    = 1'b0;
    flipper_enable = 1'b0;
    tilt           = 1'b0;
    game_over      = 1'b0;
    unique case (1'b1)
      st == PLAY: begin
        ball_enable    = 1'b1;
        flipper_enable = 1'b1;
      end
      st == TILT: begin
        ball_enable = 1'b1;
        tilt        = 1'b1;
      end
      st == OVER: game_over = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed stimulus with an event scoreboard.
// Every output event is popped against a hand-computed expectation.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       launch_btn = 1'b0;
  logic       shake_btn = 1'b0;
  logic       ball_lost = 1'b0;
  logic       score_in = 1'b0;
  logic [2:0] state;
  logic       ball_enable;
  logic       flipper_enable;
  logic       launch;
  logic       score_clear;
  logic       score_out;
  logic [2:0] balls_left;
  logic       tilt;
  logic       game_over;

  game_sequencer dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .start_btn(start_btn),
    .launch_btn(launch_btn),
    .shake_btn(shake_btn),
    .ball_lost(ball_lost),
    .score_in(score_in),
    .state(state),
    .ball_enable(ball_enable),
    .flipper_enable(flipper_enable),
    .launch(launch),
    .score_clear(score_clear),
    .score_out(score_out),
    .balls_left(balls_left),
    .tilt(tilt),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] st;
    logic [2:0] bl;
    logic       l;
    logic       c;
    logic       s;
    int         at;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  logic [2:0] prev_st = '0;
  logic [2:0] prev_bl = '0;

  // {state, balls_left, ball_en, flip_en, launch, clear, score, tilt, over}
  function automatic logic [12:0] outs();
    return {state, balls_left, ball_enable, flipper_enable,
            launch, score_clear, score_out, tilt, game_over};
  endfunction

  function automatic logic [12:0] pack(exp_t e);
    logic be, fe, ti, go;
    be = (e.st == 3'd2) || (e.st == 3'd3);
    fe = (e.st == 3'd2);
    ti = (e.st == 3'd3);
    go = (e.st == 3'd5);
    return {e.st, e.bl, be, fe, e.l, e.c, e.s, ti, go};
  endfunction

  task automatic expect_ev(input logic [2:0] st, input logic [2:0] bl,
                           input logic l, input logic c, input logic s,
                           input int at);
    exp_t e;
    e.st = st; e.bl = bl; e.l = l; e.c = c; e.s = s; e.at = at;
    q.push_back(e);
  endtask

  // monitor: any state/ball change or output pulse is one event
  always @(negedge clk) begin : monitor
    logic [12:0] obs;
    logic [12:0] want;
    exp_t        e;
    if (mon_en && (state !== prev_st || balls_left !== prev_bl ||
                   launch || score_clear || score_out)) begin
      obs = outs();
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %b at cycle %0d, required no event",
                 obs, cyc);
      end else begin
        e    = q.pop_front();
        want = pack(e);
        if (obs !== want || (e.at >= 0 && e.at != cyc)) begin
          errors++;
          $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d",
                   obs, cyc, want, e.at);
        end
      end
    end
    prev_st <= state;
    prev_bl <= balls_left;
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       start_btn = v;
      1:       launch_btn = v;
      default: shake_btn = v;
    endcase
  endtask

  // press event fires on the second frame tick after assertion
  task automatic press(input int b);
    set_btn(b, 1'b1);
    frames(2);
    set_btn(b, 1'b0);
    frames(2);
  endtask

  task automatic pulse_score();
    score_in = 1'b1;
    @(negedge clk);
    score_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_lost();
    ball_lost = 1'b1;
    @(negedge clk);
    ball_lost = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain_q(input int bound, input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      frame();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events pending after %0d frames, required 0",
               name, q.size(), bound);
      q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(outs()), 32'd0);
    mon_en = 1'b1;

    // start held across many frames: exactly one clear pulse
    expect_ev(3'd1, 3'd3, 1'b0, 1'b1, 1'b0, -1);
    start_btn = 1'b1;
    frames(6);
    start_btn = 1'b0;
    frames(2);
    drain_q(4, "start");

    expect_ev(3'd2, 3'd3, 1'b1, 1'b0, 1'b0, -1);
    press(1);
    drain_q(4, "launch1");
    expect_ev(3'd2, 3'd3, 1'b0, 1'b0, 1'b1, cyc + 1);
    pulse_score();
    expect_ev(3'd2, 3'd3, 1'b0, 1'b0, 1'b1, cyc + 1);
    pulse_score();
    drain_q(2, "score");

    // three shakes inside the window -> tilt, score gated
    press(2);
    press(2);
    expect_ev(3'd3, 3'd3, 1'b0, 1'b0, 1'b0, -1);
    press(2);
    drain_q(2, "tilt");
    pulse_score();
    expect_ev(3'd4, 3'd2, 1'b0, 1'b0, 1'b0, -1);
    pulse_lost();
    expect_ev(3'd1, 3'd2, 1'b0, 1'b0, 1'b0, -1);
    drain_q(100, "drain1");

    // window expiry clears the shake count
    expect_ev(3'd2, 3'd2, 1'b1, 1'b0, 1'b0, -1);
    press(1);
    drain_q(4, "launch2");
    press(2);
    press(2);
    frames(121);
    press(2);
    frames(2);
    expect_ev(3'd4, 3'd1, 1'b0, 1'b0, 1'b0, -1);
    pulse_lost();
    expect_ev(3'd1, 3'd1, 1'b0, 1'b0, 1'b0, -1);
    drain_q(100, "drain2");

    // last ball: exact drain and over lengths
    expect_ev(3'd2, 3'd1, 1'b1, 1'b0, 1'b0, -1);
    press(1);
    drain_q(4, "launch3");
    expect_ev(3'd4, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    pulse_lost();
    expect_ev(3'd5, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    frames(89);
    check("drain_not_early", 32'(q.size()), 32'd1);
    drain_q(2, "drain3");
    expect_ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    frames(239);
    check("over_not_early", 32'(q.size()), 32'd1);
    drain_q(2, "over");

    // new game; ball_lost beats the third shake, score still passes
    expect_ev(3'd1, 3'd3, 1'b0, 1'b1, 1'b0, -1);
    press(0);
    drain_q(4, "start2");
    expect_ev(3'd2, 3'd3, 1'b1, 1'b0, 1'b0, -1);
    press(1);
    drain_q(4, "launch4");
    press(2);
    press(2);
    expect_ev(3'd4, 3'd2, 1'b0, 1'b0, 1'b1, -1);
    shake_btn = 1'b1;
    frame();
    frame_tick = 1'b1;
    ball_lost  = 1'b1;
    score_in   = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    ball_lost  = 1'b0;
    score_in   = 1'b0;
    repeat (3) @(negedge clk);
    shake_btn = 1'b0;
    frames(2);
    drain_q(2, "lost_beats_tilt");
    expect_ev(3'd1, 3'd2, 1'b0, 1'b0, 1'b0, -1);
    drain_q(100, "drain4");

    // ignored inputs: ball_lost in SERVE, start in PLAY
    pulse_lost();
    frames(2);
    expect_ev(3'd2, 3'd2, 1'b1, 1'b0, 1'b0, -1);
    press(1);
    drain_q(4, "launch5");
    press(0);
    frames(1);

    // reset mid-game
    expect_ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_game", 32'(outs()), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the pinball design; sits between the player buttons and the pinball logic, points and buzzer blocks.
- Sequences the game through attract, serve, play, tilt, drain and game-over phases, and counts the balls remaining.
- Gates physics, flippers and scoring, issues the launch pulse, and clears the score counter at the start of each game.
- All timing is counted in video frames using a one-cycle frame tick from the VGA sync block.

Parameters:
- BALLS_PER_GAME, 3, balls per game; legal range 1..7.
- TILT_LIMIT, 3, accepted shake presses within one window that cause a tilt; legal range 1..7.
- TILT_WINDOW, 120, frames after the first shake press before the shake count clears; legal range 1..255.
- DRAIN_FRAMES, 90, frames spent in DRAIN after a ball is lost; legal range 1..255.
- OVER_FRAMES, 240, frames spent in OVER before returning to IDLE; legal range 1..255.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- frame_tick, in, 1, one-cycle pulse once per frame.
- start_btn, in, 1, raw start button.
- launch_btn, in, 1, raw launch button.
- shake_btn, in, 1, raw shake button.
- ball_lost, in, 1, one-cycle pulse from the pinball logic when the ball drains.
- score_in, in, 1, one-cycle pulse from the pinball logic when a target is hit.
- state, out, 3, IDLE=0, SERVE=1, PLAY=2, TILT=3, DRAIN=4, OVER=5.
- ball_enable, out, 1, enables ball physics.
- flipper_enable, out, 1, allows the flippers to respond.
- launch, out, 1, one-cycle ball launch pulse.
- score_clear, out, 1, one-cycle clear pulse to the points block.
- score_out, out, 1, gated score pulse to the points block and buzzer.
- balls_left, out, 3, number of balls remaining.
- tilt, out, 1, high while in TILT.
- game_over, out, 1, high while in OVER.

Behaviour:

Reset:
- On rst, the block enters IDLE.
- All outputs are 0, including balls_left.
- Tilt count, window counter, frame counter and button sample registers are all cleared.
- A reset mid-game takes effect on the next clock edge, regardless of state.

Button handling:
- Each raw button passes through a 2-flop synchroniser.
- The synchronised value is sampled only on cycles where frame_tick=1.
- A press event is a 0 to 1 change between consecutive samples. It is one cycle wide and occurs on the frame_tick cycle.
- A button held high generates exactly one press event.

score_out:
- score_out = score_in AND (state==PLAY), registered, so it has 1-cycle latency.
- No score is passed in TILT or any other state.

Combinational state outputs:
- ball_enable=1 in PLAY and TILT.
- flipper_enable=1 in PLAY only.
- tilt=1 in TILT only.
- game_over=1 in OVER only.

State transitions:
- IDLE:
  - start press: score_clear=1 for one cycle, balls_left loads BALLS_PER_GAME, go to SERVE.
  - All other presses are ignored.
- SERVE:
  - launch press: launch=1 for one cycle, tilt count cleared, go to PLAY.
  - ball_lost in SERVE is ignored.
- PLAY:
  - Each shake press increments the tilt count, saturating at 7.
  - The first press of a window also loads the window counter with TILT_WINDOW.
  - The window counter decrements on each frame_tick. When it reaches 0, the tilt count clears.
  - When the tilt count reaches TILT_LIMIT, go to TILT.
  - ball_lost: go to DRAIN. ball_lost takes priority over a tilt in the same cycle.
  - A score_in arriving in the same cycle as ball_lost is still passed to score_out.
- TILT:
  - ball_lost: go to DRAIN.
  - Shake and launch presses are ignored.
- DRAIN:
  - On entry, balls_left decrements by 1, saturating at 0, and the frame counter loads DRAIN_FRAMES.
  - The frame counter decrements on frame_tick.
  - When the counter reaches 0: go to OVER if balls_left==0, else go to SERVE.
- OVER:
  - On entry, the frame counter loads OVER_FRAMES.
  - start press: same action as the IDLE start (score_clear, reload balls_left, go to SERVE).
  - When the counter reaches 0: go to IDLE.
  - A start press on the same cycle the counter expires takes priority.

Other rules:
- Start presses outside IDLE and OVER are ignored.
- ball_lost outside PLAY and TILT is ignored.
- Exactly one transition per clock.
- Unused state encodings (6, 7) go to IDLE.

Test Plan:
- Reset, then pulse start across a frame_tick -> score_clear pulses for 1 cycle, balls_left=3, state=1; holding start produces no second pulse.
- In SERVE, press launch, then pulse score_in twice -> launch pulses for 1 cycle, state=2, two score_out pulses each 1 cycle after score_in.
- In PLAY, press shake 3 times within 120 frames -> state=3, flipper_enable=0, a following score_in gives no score_out; then ball_lost -> state=4, balls_left=2.
- In PLAY, press shake 2 times, wait 121 frames, press shake once -> state stays 2 (count cleared by the window).
- Lose 3 balls in succession, with the drain lasting 90 frames each -> after the third drain state=5 and game_over=1; with no press for 240 frames -> state=0.
- Assert ball_lost and the 3rd shake press in the same cycle -> state=4, not 3; assert rst in PLAY -> state=0 and all outputs 0 on the next edge.
